// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: region codes, FSM state
// encoding and the address decode helper.
package mio_pkg;

    localparam logic [3:0]  REG_RAM      = 4'h0;
    localparam logic [3:0]  REG_GPIO     = 4'hE;
    localparam logic [3:0]  REG_CNT      = 4'hF;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RG_RAM  = 2'd0,
        RG_GPIO = 2'd1,
        RG_CNT  = 2'd2,
        RG_NONE = 2'd3
    } region_t;

    function automatic region_t decode_region(input logic [3:0] code);
        case (code)
            REG_RAM:  return RG_RAM;
            REG_GPIO: return RG_GPIO;
            REG_CNT:  return RG_CNT;
            default:  return RG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mio_ram.sv
// Single-port word RAM with registered read output; the output register
// only updates on a read strobe so it holds the last read word.
module mio_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Slave end of the CPU MIO handshake: decodes RAM / GPIO / cycle counter,
// inserts RAM wait states and returns a one-cycle mio_ready with read data.
//
// state | meaning
// IDLE  | waiting for cpu_mio; bus inputs sampled only here
// WAIT  | RAM wait states counting down
// ACK   | mio_ready high; writes commit on the edge leaving this state
// DONE  | waiting for cpu_mio to drop so a held request is not re-run
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mio,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mio_ready,
    output logic [31:0] rdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        bus_err
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state;
    region_t             region_q;
    logic                mem_w_q;
    logic [RAM_AW-1:0]   ram_idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wait_cnt;
    logic [31:0]         cnt;
    logic [31:0]         rdata_q;
    logic                rdata_ram;
    logic [31:0]         ram_q;
    logic [31:0]         io_rdata;

    region_t             region_in;
    region_t             enter_region;
    logic                enter_wr;
    logic                enter_ack;
    logic                ram_re;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic                ack_commit;
    logic                addr_unused;

    assign addr_unused  = ^{addr[27:RAM_AW+2], addr[1:0]};
    assign region_in    = decode_region(addr[31:28]);

    // In IDLE the live bus describes the transaction; afterwards the latched copy does.
    assign enter_region = (state == S_IDLE) ? region_in : region_q;
    assign enter_wr     = (state == S_IDLE) ? mem_w : mem_w_q;
    assign enter_ack    = ((state == S_IDLE) && cpu_mio &&
                           !((region_in == RG_RAM) && (WAIT_CYCLES > 0))) ||
                          ((state == S_WAIT) && (wait_cnt == 4'd0));
    assign ram_addr     = (state == S_IDLE) ? addr[RAM_AW+1:2] : ram_idx_q;
    assign ram_re       = enter_ack && (enter_region == RG_RAM) && !enter_wr;
    assign ack_commit   = (state == S_ACK) && mem_w_q;
    assign ram_we       = ack_commit && (region_q == RG_RAM);

    // RAM read data stays in the RAM output register instead of being copied.
    assign rdata        = rdata_ram ? ram_q : rdata_q;

    always_comb begin
        io_rdata = '0;
        if (!enter_wr) begin
            case (enter_region)
                RG_GPIO: io_rdata = {16'h0, sw_in};
                RG_CNT:  io_rdata = cnt;
                RG_NONE: io_rdata = ERR_DATA;
                default: io_rdata = '0;
            endcase
        end
    end

    mio_ram #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            region_q  <= RG_NONE;
            mem_w_q   <= 1'b0;
            ram_idx_q <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            mio_ready <= 1'b0;
            rdata_q   <= '0;
            rdata_ram <= 1'b0;
        end else begin
            mio_ready <= enter_ack;
            if (enter_ack) begin
                rdata_ram <= ram_re;
                rdata_q   <= io_rdata;
            end
            case (state)
                S_IDLE: begin
                    if (cpu_mio) begin
                        region_q  <= region_in;
                        mem_w_q   <= mem_w;
                        ram_idx_q <= addr[RAM_AW+1:2];
                        wdata_q   <= wdata;
                        if ((region_in == RG_RAM) && (WAIT_CYCLES > 0)) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= S_ACK;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= S_ACK;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                S_ACK:   state <= S_DONE;
                S_DONE:  if (!cpu_mio) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            led_out <= '0;
            bus_err <= 1'b0;
        end else begin
            if (ack_commit && (region_q == RG_CNT))
                cnt <= wdata_q;
            else
                cnt <= cnt + 32'd1;
            if (ack_commit && (region_q == RG_GPIO))
                led_out <= wdata_q[15:0];
            if (enter_ack && (enter_region == RG_NONE))
                bus_err <= 1'b1;
        end
    end

endmodule
